multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main controller for the multi-cycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback.
//  Drives all datapath mux selects and write strobes, including ALU-B select 3 (sign-extended imm << 2) for the branch target.
//  Stalls on a shared instruction/data memory via a mem_ready handshake.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode
//  OP_LW     6'h23  load word
//  OP_SW     6'h2B  store word
//  OP_BEQ    6'h04  branch if equal
//  OP_ADDI   6'h08  add immediate
//  OP_J      6'h02  jump
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   6  instr[31:26] from instruction register
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  pc_en       out  1  PC register write enable
//  i_or_d      out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read    out  1  memory read request
//  mem_write   out  1  memory write request
//  ir_write    out  1  instruction register load
//  reg_dst     out  1  destination select: 0=rt, 1=rd
//  mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
//  reg_write   out  1  register file write enable
//  alu_src_a   out  1  ALU A select: 0=PC, 1=rs
//  alu_src_b   out  2  ALU B select: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op      out  2  0=add, 1=sub, 2=funct-decoded
//  pc_src      out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
//  state       out  4  current state encoding, for debug
//  illegal_op  out  1  sticky illegal-opcode flag (only with macro)
// BEHAVIOUR
//  - Moore state register. Outputs decode from state; pc_en and ir_write are additionally gated by mem_ready/zero.
//    Any output not listed for a state is 0.
//  - States: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8 BRANCH=9 ADDIEX=10 ADDIWB=11 JUMP=12 TRAP=13.
//  - Reset (async, rst_n=0): state=IDLE, illegal_op=0, every output 0. IDLE -> FETCH after one clock.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_b=1, alu_op=0, pc_src=0.
//    ir_write=pc_en=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (precompute branch target). Next state by opcode:
//    LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->see CONFIGURATION.
//  - MEMADR: alu_src_a=1, alu_src_b=2. Next: MEMRD for LW, MEMWR for SW.
//  - MEMRD: i_or_d=1, mem_read=1. Hold until mem_ready=1, then MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
//  - MEMWR: i_or_d=1, mem_write=1. Hold until mem_ready=1, then FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next ALUWB.
//  - ALUWB: reg_write=1, reg_dst=1. Next FETCH.
//  - BRANCH: alu_src_a=1, alu_op=1, pc_src=1, pc_en=zero. Next FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=2. Next ADDIWB.
//  - ADDIWB: reg_write=1, reg_dst=0. Next FETCH.
//  - JUMP: pc_src=2, pc_en=1. Next FETCH.
//  - Latency with zero wait states: R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
//    Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
//  - mem_read and mem_write are never both 1. reg_write and pc_en are never both 1 in the same cycle.
//  - Reset asserted mid-instruction: abort immediately, no partial write.
//    Strobes drop in the same cycle reset asserts (combinational decode of the async-cleared state).
// CONFIGURATION
//  - MC_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE goes to TRAP.
//    illegal_op is set the cycle TRAP is entered and stays 1. TRAP holds with all strobes 0. Only reset exits TRAP.
//  - MC_ILLEGAL_TRAP_EN undefined: an unknown opcode in DECODE goes to FETCH (executes as a NOP, 2 cycles).
//    illegal_op is tied to 0 and the TRAP state is never reached.
// TESTING
//  - Reset: rst_n=0 at any state -> state=0 and all outputs 0 at once. Release -> state=1 after one clk.
//  - R-type, mem_ready=1: opcode=00 -> states 1,2,7,8. reg_write=1 only in 8, with reg_dst=1. Back to 1.
//  - LW with 2 wait cycles in MEMRD: opcode=23 -> 1,2,3,4,4,4,5. mem_to_reg=1 and reg_write=1 in 5.
//  - BEQ: opcode=04, zero=1 -> pc_en=1 and pc_src=1 in BRANCH. With zero=0 -> pc_en stays 0. DECODE shows alu_src_b=3.
//  - FETCH stall: mem_ready=0 for 3 cycles -> state 1 holds, ir_write=pc_en=0. First mem_ready=1 -> both 1 for one cycle.
//  - Illegal opcode 6'h3F: with MC_ILLEGAL_TRAP_EN -> state 13, illegal_op=1 held until reset.
//    Without the macro -> back to state 1, illegal_op=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal_op) instead of acting as a NOP.
module multicycle_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JUMP   = 4'd12, TRAP   = 4'd13
  } state_t;

  state_t cur;
  logic   ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= IDLE;
      ill_q <= 1'b0;
    end else begin
      case (cur)
        IDLE:   cur <= FETCH;
        FETCH:  if (mem_ready) cur <= DECODE;
        DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW) cur <= MEMADR;
          else if (opcode == OP_RTYPE)            cur <= EXEC;
          else if (opcode == OP_BEQ)              cur <= BRANCH;
          else if (opcode == OP_ADDI)             cur <= ADDIEX;
          else if (opcode == OP_J)                cur <= JUMP;
          else begin
`ifdef MC_ILLEGAL_TRAP_EN
            cur   <= TRAP;
            ill_q <= 1'b1;
`else
            cur <= FETCH;
`endif
          end
        end
        MEMADR: cur <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) cur <= MEMWB;
        MEMWB:  cur <= FETCH;
        MEMWR:  if (mem_ready) cur <= FETCH;
        EXEC:   cur <= ALUWB;
        ALUWB:  cur <= FETCH;
        BRANCH: cur <= FETCH;
        ADDIEX: cur <= ADDIWB;
        ADDIWB: cur <= FETCH;
        JUMP:   cur <= FETCH;
        TRAP:   cur <= TRAP;
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = ill_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Outputs decode straight from the state register so an async reset silences every strobe at once.
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_src     = 2'd0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      DECODE: alu_src_b = 2'd3;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_en     = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'd2;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed + randomized bench for multicycle_ctrl_fsm; checks every cycle against a per-state output table.
// Honours MC_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_ctrl_fsm;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JUMP = 4'd12, S_TRAP = 4'd13;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic       illegal_op;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal_op(illegal_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [19:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        exp_ill = 1'b0;

  // Packed as {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //            reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}.
  function automatic logic [19:0] expect_vec(logic [3:0] st, logic z, logic mr, logic ill);
    logic [8:0] s;
    logic [1:0] b, op, ps;
    s = '0; b = 2'd0; op = 2'd0; ps = 2'd0;
    case (st)
      S_FETCH:  begin s = {mr, 1'b0, 1'b1, 1'b0, mr, 4'b0000}; b = 2'd1; end
      S_DECODE: b = 2'd3;
      S_MEMADR: begin s = 9'b000000001; b = 2'd2; end
      S_MEMRD:  s = 9'b011000000;
      S_MEMWB:  s = 9'b000000110;
      S_MEMWR:  s = 9'b010100000;
      S_EXEC:   begin s = 9'b000000001; op = 2'd2; end
      S_ALUWB:  s = 9'b000001010;
      S_BRANCH: begin s = {z, 8'b00000001}; op = 2'd1; ps = 2'd1; end
      S_ADDIEX: begin s = 9'b000000001; b = 2'd2; end
      S_ADDIWB: s = 9'b000000010;
      S_JUMP:   begin s = 9'b100000000; ps = 2'd2; end
      default:  ;
    endcase
    return {st, s, b, op, ps, ill};
  endfunction

  task automatic check_out(input string tag);
    logic [19:0] e, o;
    o = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
         reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d)", tag, o, e, o[19:16], e[19:16]);
      end
    end
    checks++;
    assert (!(mem_read && mem_write) && !(reg_write && pc_en)) else begin
      errors++;
      $error("FAIL %s_excl: observed rd=%b wr=%b rw=%b pc=%b expected no overlap",
             tag, mem_read, mem_write, reg_write, pc_en);
    end
  endtask

  // driver: apply inputs for one cycle, predict outputs for the expected state, check mid-cycle
  task automatic drive(input logic [5:0] op, input logic z, input logic mr, input logic [3:0] st,
                       input string tag);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    if (st == S_TRAP) exp_ill = 1'b1;
    exp_q.push_back(expect_vec(st, z, mr, exp_ill));
    #1 check_out(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_ill = 1'b0;
    exp_q.push_back(expect_vec(S_IDLE, zero, mem_ready, 1'b0));
    #1 check_out("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(expect_vec(S_IDLE, zero, mem_ready, 1'b0));
    #1 check_out("reset_release");
  endtask

  // One full instruction: fw fetch stalls, mw memory stalls; non-memory cycles get random mem_ready.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           input string tag);
    for (int i = 0; i < fw; i++) drive(op, z, 1'b0, S_FETCH, {tag, "_fstall"});
    drive(op, z, 1'b1, S_FETCH, {tag, "_fetch"});
    drive(op, z, 1'($urandom_range(0, 1)), S_DECODE, {tag, "_decode"});
    case (op)
      6'h23: begin
        drive(op, z, 1'($urandom_range(0, 1)), S_MEMADR, {tag, "_memadr"});
        for (int i = 0; i < mw; i++) drive(op, z, 1'b0, S_MEMRD, {tag, "_rdstall"});
        drive(op, z, 1'b1, S_MEMRD, {tag, "_memrd"});
        drive(op, z, 1'($urandom_range(0, 1)), S_MEMWB, {tag, "_memwb"});
      end
      6'h2B: begin
        drive(op, z, 1'($urandom_range(0, 1)), S_MEMADR, {tag, "_memadr"});
        for (int i = 0; i < mw; i++) drive(op, z, 1'b0, S_MEMWR, {tag, "_wrstall"});
        drive(op, z, 1'b1, S_MEMWR, {tag, "_memwr"});
      end
      6'h00: begin
        drive(op, z, 1'($urandom_range(0, 1)), S_EXEC, {tag, "_exec"});
        drive(op, z, 1'($urandom_range(0, 1)), S_ALUWB, {tag, "_aluwb"});
      end
      6'h04: drive(op, z, 1'($urandom_range(0, 1)), S_BRANCH, {tag, "_branch"});
      6'h08: begin
        drive(op, z, 1'($urandom_range(0, 1)), S_ADDIEX, {tag, "_addiex"});
        drive(op, z, 1'($urandom_range(0, 1)), S_ADDIWB, {tag, "_addiwb"});
      end
      6'h02: drive(op, z, 1'($urandom_range(0, 1)), S_JUMP, {tag, "_jump"});
      default: ;  // unknown opcode without trap: DECODE returns straight to FETCH
    endcase
  endtask

  logic [5:0] ops [6];

  initial begin
    rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;

    do_reset();
    run_instr(6'h00, 1'b0, 0, 0, "rtype");
    run_instr(6'h23, 1'b0, 0, 2, "lw_wait2");
    run_instr(6'h2B, 1'b0, 0, 0, "sw");
    run_instr(6'h04, 1'b1, 0, 0, "beq_taken");
    run_instr(6'h04, 1'b0, 0, 0, "beq_not");
    run_instr(6'h08, 1'b0, 3, 0, "addi_fstall3");
    run_instr(6'h02, 1'b0, 0, 0, "jump");
    run_instr(6'h2B, 1'b1, 1, 2, "sw_wait");

    // reset in the middle of a stalled load
    drive(6'h23, 1'b0, 1'b1, S_FETCH, "abort_fetch");
    drive(6'h23, 1'b0, 1'b0, S_DECODE, "abort_decode");
    drive(6'h23, 1'b0, 1'b0, S_MEMADR, "abort_memadr");
    drive(6'h23, 1'b0, 1'b0, S_MEMRD, "abort_memrd");
    do_reset();

    for (int n = 0; n < 30; n++)
      run_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3), "rand");

    // illegal opcode
    drive(6'h3F, 1'b0, 1'b1, S_FETCH, "ill_fetch");
    drive(6'h3F, 1'b0, 1'b1, S_DECODE, "ill_decode");
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) drive(6'h00, 1'b1, 1'b1, S_TRAP, "ill_trap_hold");
    do_reset();
`endif
    run_instr(6'h08, 1'b0, 0, 0, "after_ill");
    drive(6'h00, 1'b0, 1'b1, S_FETCH, "final_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
